score_bcd_encoder: RTL

SCORE_BCD_ENCODER -- requirements
Module: score_bcd_encoder

---
 rtl/score_bcd_encoder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/score_bcd_encoder.sv
// -----------------------------------------------------------------------------
// score_bcd_encoder
//
// Purpose:
//   Converts an unsigned binary score into packed BCD using the sequential
//   shift-and-add-3 (double dabble) algorithm. One bit is consumed per clock,
//   so a conversion takes BIN_W shift cycles plus one cycle to publish the
//   result. The result registers hold their value between conversions.
//
// Parameters:
//   BIN_W   width of the binary input value
//   DIGITS  number of BCD digits produced
//
// Ports:
//   in_CLK     clock, all state changes on the rising edge
//   in_RST_N   asynchronous active-low reset
//   in_START   conversion request, only honoured while idle
//   in_BIN     binary value to convert, captured when the request is taken
//   out_BUSY   high while a conversion is in flight (SHIFT or DONE)
//   out_DONE   single-cycle pulse, out_BCD/out_OVF/out_BLANK just updated
//   out_BCD    packed BCD, digit i in bits [4i+3:4i], digit 0 least significant
//   out_OVF    last value did not fit in DIGITS digits (out_BCD = value mod
//              10^DIGITS in that case)
//   out_BLANK  leading-zero mask, bit i high when digit i is a leading zero
//
// Configuration:
//   SCORE_BCD_ENCODER_BLANK_EN  when defined, out_BLANK carries the
//                               leading-zero mask; otherwise it is tied low.
// -----------------------------------------------------------------------------
module score_bcd_encoder #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  in_CLK,
  input  logic                  in_RST_N,
  input  logic                  in_START,
  input  logic [BIN_W-1:0]      in_BIN,
  output logic                  out_BUSY,
  output logic                  out_DONE,
  output logic [4*DIGITS-1:0]   out_BCD,
  output logic                  out_OVF,
  output logic [DIGITS-1:0]     out_BLANK
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Pre-shift correction of one BCD digit: a digit of 5 or more would exceed
  // 9 once doubled, so adding 3 first makes the doubling carry into the next
  // digit exactly like a decimal carry.
  function automatic logic [3:0] add3_adjust(input logic [3:0] digit);
    logic [3:0] result;
    if (digit >= 4'd5) begin
      result = digit + 4'd3;
    end else begin
      result = digit;
    end
    return result;
  endfunction

  state_t               state_r;
  state_t               state_nx_s;

  logic [BIN_W-1:0]     bin_r;
  logic [BCD_W-1:0]     scratch_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 ovf_acc_r;

  logic [BCD_W-1:0]     adj_s;
  logic [BCD_W-1:0]     scratch_shift_s;
  logic [BIN_W-1:0]     bin_shift_s;
  logic                 carry_out_s;
  logic [DIGITS-1:0]    blank_s;

  logic                 busy_r;
  logic                 done_r;
  logic [BCD_W-1:0]     bcd_r;
  logic                 ovf_r;
  logic [DIGITS-1:0]    blank_r;

  // Digit correction followed by the one-bit left shift of {scratch, binary}.
  always_comb begin
    adj_s = scratch_r;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = add3_adjust(scratch_r[4*i +: 4]);
    end
    // The top bit of the corrected scratch is worth 10^DIGITS once shifted,
    // so it is dropped here and only remembered as an overflow.
    carry_out_s     = adj_s[BCD_W-1];
    scratch_shift_s = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
    bin_shift_s     = bin_r << 1;
  end

`ifdef SCORE_BCD_ENCODER_BLANK_EN
  // Leading-zero mask: walk from the top digit down, a digit is blank while
  // every digit above it (and itself) is zero. Digit 0 is never blanked so a
  // zero score still shows a single "0".
  always_comb begin
    logic zero_run;
    blank_s  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch_r[4*i +: 4] == 4'd0) begin
        zero_run = zero_run;
      end else begin
        zero_run = 1'b0;
      end
      blank_s[i] = zero_run;
    end
    blank_s[0] = 1'b0;
  end
`else
  // Blanking disabled in this build: mask is permanently clear.
  always_comb begin
    blank_s = '0;
  end
`endif

  // Next-state logic of the conversion sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_START) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // The counter is sampled before this cycle's decrement, so a value of
        // one means this edge performs the last shift.
        if (cnt_r == CNT_ONE) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Conversion working registers: captured input, BCD scratch, bit counter
  // and the sticky overflow flag for the current conversion.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      bin_r     <= '0;
      scratch_r <= '0;
      cnt_r     <= CNT_ZERO;
      ovf_acc_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_START) begin
            bin_r     <= in_BIN;
            scratch_r <= '0;
            cnt_r     <= CNT_LOAD;
            ovf_acc_r <= 1'b0;
          end else begin
            bin_r     <= bin_r;
            scratch_r <= scratch_r;
            cnt_r     <= cnt_r;
            ovf_acc_r <= ovf_acc_r;
          end
        end
        ST_SHIFT: begin
          bin_r     <= bin_shift_s;
          scratch_r <= scratch_shift_s;
          cnt_r     <= cnt_r - CNT_ONE;
          ovf_acc_r <= ovf_acc_r | carry_out_s;
        end
        default: begin
          bin_r     <= bin_r;
          scratch_r <= scratch_r;
          cnt_r     <= cnt_r;
          ovf_acc_r <= ovf_acc_r;
        end
      endcase
    end
  end

  // Output registers: the result is published on the edge that leaves DONE,
  // which puts out_DONE BIN_W+1 cycles after the accepting edge.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
      ovf_r   <= 1'b0;
      blank_r <= '0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      if (state_r == ST_DONE) begin
        done_r  <= 1'b1;
        bcd_r   <= scratch_r;
        ovf_r   <= ovf_acc_r;
        blank_r <= blank_s;
      end else begin
        done_r  <= 1'b0;
        bcd_r   <= bcd_r;
        ovf_r   <= ovf_r;
        blank_r <= blank_r;
      end
    end
  end

  assign out_BUSY  = busy_r;
  assign out_DONE  = done_r;
  assign out_BCD   = bcd_r;
  assign out_OVF   = ovf_r;
  assign out_BLANK = blank_r;

endmodule
